chunked_add_sub: RTL and testbench

CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

---
 rtl/add_sub_pkg.sv | 17 +
 rtl/chunk_adder.sv | 22 ++
 rtl/chunked_add_sub.sv | 127 ++++++++++++
 tb/tb_chunked_add_sub.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding, mode
// constants and default geometry.
package add_sub_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_CHUNK = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational adder slice; also exposes the carry into its MSB so
// the caller can derive signed overflow on the final slice.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             msb_cin_o
);

   logic [CHUNK:0] full;

   assign full      = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
   assign sum_o     = full[CHUNK-1:0];
   assign cout_o    = full[CHUNK];
   // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out by XOR.
   assign msb_cin_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB first, with a
// valid/ready handshake on both operand and result sides.
module chunked_add_sub
   import add_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned N    = (CHUNK == 0) ? 0 : WIDTH / CHUNK;
   localparam bit          Bad  = (CHUNK == 0) ? 1'b1 : ((WIDTH % CHUNK) != 0) || (N == 0);
   localparam int unsigned IdxW = $clog2(N + 1);

   if (Bad) begin : g_bad_params
      $error("chunked_add_sub: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;   // holds B' = B ^ {WIDTH{m}}
   logic [WIDTH-1:0]  s_q, s_d;
   logic              carry_q, carry_d;
   logic              co_q, co_d;
   logic              ovf_q, ovf_d;
   logic [IdxW-1:0]   idx_q, idx_d;

   int unsigned       base;
   logic [CHUNK-1:0]  sum;
   logic              cout;
   logic              msb_cin;

   assign base = 32'(idx_q) * CHUNK;

   chunk_adder #(
      .CHUNK(CHUNK)
   ) u_chunk_adder (
      .a_i      (a_q[base +: CHUNK]),
      .b_i      (b_q[base +: CHUNK]),
      .cin_i    (carry_q),
      .sum_o    (sum),
      .cout_o   (cout),
      .msb_cin_o(msb_cin)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{m}};
               carry_d = m;
               idx_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            s_d[base +: CHUNK] = sum;
            carry_d            = cout;
            idx_d              = idx_q + 1'b1;
            if (idx_q == IdxW'(N - 1)) begin
               co_d    = cout;
               // Overflow iff carry into the MSB differs from carry out of it.
               ovf_d   = cout ^ msb_cin;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign s         = s_q;
   assign co        = co_q;
   assign ovf       = ovf_q;
   assign zero      = (s_q == '0);

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub at 16/4, 32/8 and 8/8 geometries.
module tb_chunked_add_sub;

   typedef struct {
      int          inst;
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] op_a, op_b;
   logic        op_m;
   logic [2:0]  in_valid, in_ready, out_valid, out_ready, co, ovf, zero;
   logic [15:0] s0;
   logic [31:0] s1;
   logic [7:0]  s2;
   logic [31:0] s_w [3];

   assign s_w[0] = {16'h0, s0};
   assign s_w[1] = s1;
   assign s_w[2] = {24'h0, s2};

   int lat_exp [3] = '{4, 4, 1};
   int n_pass  = 0;
   int n_total = 0;

   chunked_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(op_a[15:0]), .b(op_b[15:0]), .m(op_m), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .s(s0), .co(co[0]), .ovf(ovf[0]), .zero(zero[0])
   );

   chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(op_a), .b(op_b), .m(op_m), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .s(s1), .co(co[1]), .ovf(ovf[1]), .zero(zero[1])
   );

   chunked_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(op_a[7:0]), .b(op_b[7:0]), .m(op_m), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .s(s2), .co(co[2]), .ovf(ovf[2]), .zero(zero[2])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic start_op(input int i, input logic mm, input logic [31:0] aa,
                           input logic [31:0] bb, input string name);
      check({name, " in_ready idle"}, 32'(in_ready[i]), 32'd1);
      op_a        = aa;
      op_b        = bb;
      op_m        = mm;
      in_valid[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[i] = 1'b0;
      op_a        = $urandom;
      op_b        = $urandom;
      op_m        = ~mm;
   endtask

   task automatic wait_done(input int i, input string name);
      int lat = 0;
      while (!out_valid[i] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'(lat_exp[i]));
   endtask

   task automatic finish_op(input int i, input string name);
      out_ready[i] = 1'b1;
      @(negedge clk);
      out_ready[i] = 1'b0;
      check({name, " out_valid drop"}, 32'(out_valid[i]), 32'd0);
   endtask

   vec_t vecs [19];

   initial begin
      vecs[0]  = '{0, 1'b0, 32'd5,        32'd2,        32'h0000_0007, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{0, 1'b1, 32'd1,        32'd2,        32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{0, 1'b1, 32'd58,       32'd92,       32'h0000_FFDE, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{0, 1'b1, 32'd5,        32'd2,        32'h0000_0003, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{0, 1'b1, 32'h1234,     32'h1234,     32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{0, 1'b0, 32'h7FFF,     32'h0001,     32'h0000_8000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{0, 1'b1, 32'h8000,     32'h0001,     32'h0000_7FFF, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{0, 1'b0, 32'hFFFF,     32'h0001,     32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{0, 1'b0, 32'h8000,     32'h8000,     32'h0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{1, 1'b0, 32'h7FFF_FFFF, 32'h1,       32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1, 1'b1, 32'd1,        32'd2,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1, 1'b0, 32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{2, 1'b0, 32'd5,        32'd2,        32'h07, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{2, 1'b1, 32'd1,        32'd2,        32'hFF, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{2, 1'b0, 32'h7F,       32'h01,       32'h80, 1'b0, 1'b1, 1'b0};
      vecs[16] = '{2, 1'b1, 32'h80,       32'h01,       32'h7F, 1'b1, 1'b1, 1'b0};
      vecs[17] = '{2, 1'b1, 32'h3C,       32'h3C,       32'h00, 1'b1, 1'b0, 1'b1};
      vecs[18] = '{2, 1'b0, 32'hF0,       32'h20,       32'h10, 1'b1, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      op_a      = '0;
      op_b      = '0;
      op_m      = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst%0d in_ready", i), 32'(in_ready[i]), 32'd1);
         check($sformatf("rst%0d out_valid", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("rst%0d s", i), s_w[i], 32'd0);
         check($sformatf("rst%0d co", i), 32'(co[i]), 32'd0);
         check($sformatf("rst%0d ovf", i), 32'(ovf[i]), 32'd0);
         check($sformatf("rst%0d zero", i), 32'(zero[i]), 32'd1);
      end

      // out_ready while idle must not produce anything
      rst_n     = 1'b1;
      out_ready = '1;
      repeat (2) @(negedge clk);
      out_ready = '0;
      check("idle out_ready", 32'(out_valid), 32'd0);

      for (int k = 0; k < 19; k++) begin
         string nm;
         int    i;
         nm = $sformatf("v%0d", k);
         i  = vecs[k].inst;
         start_op(i, vecs[k].m, vecs[k].a, vecs[k].b, nm);
         wait_done(i, nm);
         check({nm, " s"}, s_w[i], vecs[k].s);
         check({nm, " co"}, 32'(co[i]), 32'(vecs[k].co));
         check({nm, " ovf"}, 32'(ovf[i]), 32'(vecs[k].ovf));
         check({nm, " zero"}, 32'(zero[i]), 32'(vecs[k].zero));
         finish_op(i, nm);
      end

      // Handshake: garbage on inputs during CALC, stall in DONE with in_valid high.
      for (int i = 0; i < 3; i++) begin
         string nm;
         int    lat;
         nm  = $sformatf("hs%0d", i);
         start_op(i, 1'b0, 32'h21, 32'h13, nm);
         lat = 0;
         while (!out_valid[i] && lat < 40) begin
            check({nm, " calc in_ready"}, 32'(in_ready[i]), 32'd0);
            in_valid[i] = ~in_valid[i];
            op_a        = $urandom;
            op_b        = $urandom;
            op_m        = ~op_m;
            @(negedge clk);
            lat++;
         end
         check({nm, " latency"}, 32'(lat), 32'(lat_exp[i]));
         for (int c = 0; c < 5; c++) begin
            in_valid[i] = 1'b1;
            op_a        = $urandom;
            @(negedge clk);
            check({nm, " hold s"}, s_w[i], 32'h34);
            check({nm, " hold in_ready"}, 32'(in_ready[i]), 32'd0);
            check({nm, " hold out_valid"}, 32'(out_valid[i]), 32'd1);
         end
         in_valid[i] = 1'b0;
         check({nm, " co"}, 32'(co[i]), 32'd0);
         check({nm, " ovf"}, 32'(ovf[i]), 32'd0);
         finish_op(i, nm);
      end

      // Reset in the middle of CALC abandons the operation.
      for (int i = 0; i < 3; i++) begin
         string nm;
         logic  seen;
         nm = $sformatf("mr%0d", i);
         start_op(i, 1'b0, 32'h55, 32'h0A, nm);
         if (lat_exp[i] > 1) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check({nm, " in_ready"}, 32'(in_ready[i]), 32'd1);
         check({nm, " out_valid"}, 32'(out_valid[i]), 32'd0);
         check({nm, " s"}, s_w[i], 32'd0);
         seen = 1'b0;
         repeat (8) begin
            @(negedge clk);
            seen |= out_valid[i];
         end
         check({nm, " no late out_valid"}, 32'(seen), 32'd0);
         start_op(i, 1'b0, 32'd15, 32'd20, {nm, " post"});
         wait_done(i, {nm, " post"});
         check({nm, " post s"}, s_w[i], 32'd35);
         finish_op(i, {nm, " post"});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
